// File: rtl/loctag_pkg.sv
// loctag_pkg: shared sampler FSM states and ADC frame geometry for the loctag front end
package loctag_pkg;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS = 12;
  localparam int ADC_LEAD_ZEROS = 4;
  typedef enum logic [2:0] {IDLE, PWRUP, SETUP, SHIFT, DONE, GAP} adc_state_e;
endpackage

// File: rtl/adc_sampler_if.sv
// adc_sampler_if: detector enable, ADC serial bus and sample stream of the sampler
interface adc_sampler_if;
  import loctag_pkg::*;
  logic en;
  logic lt5534_en;
  logic adc_cs;
  logic adc_clk;
  logic adc_so;
  logic [ADC_DATA_BITS-1:0] sample;
  logic sample_valid;
  logic frame_err;
  logic rf_on;
  modport master (
    input  en, adc_so,
    output lt5534_en, adc_cs, adc_clk, sample, sample_valid, frame_err, rf_on
  );
  modport slave (
    output en, adc_so,
    input  lt5534_en, adc_cs, adc_clk, sample, sample_valid, frame_err, rf_on
  );
endinterface

// File: rtl/adc_thresh_cmp.sv
// adc_thresh_cmp: turns the sample stream into the rf_on level.
// ADC_SAMPLER_HYST_EN selects a two-threshold hysteresis comparator.
module adc_thresh_cmp
  import loctag_pkg::*;
#(
  parameter logic [ADC_DATA_BITS-1:0] THRESH_HI = 12'd800,
  parameter logic [ADC_DATA_BITS-1:0] THRESH_LO = 12'd700
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic [ADC_DATA_BITS-1:0] sample_i,
  input  logic                     sample_valid_i,
  output logic                     rf_on_o
);
  logic rf_on_q, rf_on_d;
  if (THRESH_LO > THRESH_HI) begin : g_bad_thresh
    $error("adc_thresh_cmp: THRESH_LO above THRESH_HI");
  end
  always_comb begin
    rf_on_d = rf_on_q;
`ifdef ADC_SAMPLER_HYST_EN
    if (sample_valid_i) rf_on_d = sample_i >= THRESH_HI ? 1'b1 : sample_i < THRESH_LO ? 1'b0 : rf_on_q;
`else
    if (sample_valid_i) rf_on_d = sample_i >= THRESH_HI;
`endif
    if (clr_i) rf_on_d = 1'b0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rf_on_q <= 1'b0;
    else rf_on_q <= rf_on_d;
  assign rf_on_o = rf_on_q;
endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: LT5534 power sequencing and 16-bit serial frame capture from the 12-bit ADC.
// Define ADC_SAMPLER_HYST_EN for a hysteresis rf_on comparator.
module adc_sampler
  import loctag_pkg::*;
#(
  parameter int                       CLK_DIV   = 2,
  parameter int                       PWRUP_CYC = 100,
  parameter int                       CONV_GAP  = 4,
  parameter logic [ADC_DATA_BITS-1:0] THRESH_HI = 12'd800,
  parameter logic [ADC_DATA_BITS-1:0] THRESH_LO = 12'd700
) (
  input logic           clk,
  input logic           reset,
  adc_sampler_if.master bus
);
  adc_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] hc_q, hc_d;
  logic [3:0] bc_q, bc_d;
  logic ph_q, ph_d;
  logic [ADC_FRAME_BITS-1:0] sr_q, sr_d;
  logic [ADC_DATA_BITS-1:0] sample_q, sample_d;
  logic lt_en_q, lt_en_d, cs_q, cs_d, sclk_q, sclk_d;
  logic valid_q, valid_d, err_q, err_d;
  logic half_end, frame_ok;
  if (CLK_DIV < 1 || CLK_DIV > 15 || PWRUP_CYC < 1 || PWRUP_CYC > 65535 ||
      CONV_GAP < 1 || CONV_GAP > 255) begin : g_bad_cfg
    $error("adc_sampler: timing parameter out of range");
  end
  assign half_end = hc_q == 4'(CLK_DIV - 1);
  assign frame_ok = sr_q[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS] == '0;
  // Outputs are registered from the next state so pins change on the state edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hc_d     = hc_q;
    bc_d     = bc_q;
    ph_d     = ph_q;
    sr_d     = sr_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = bus.en ? PWRUP : IDLE;
      end
      PWRUP: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = !bus.en ? IDLE : cnt_q == 16'(PWRUP_CYC - 1) ? SETUP : PWRUP;
      end
      SETUP: begin
        hc_d    = '0;
        bc_d    = '0;
        ph_d    = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        hc_d = half_end ? '0 : hc_q + 4'd1;
        if (half_end) begin
          ph_d = !ph_q;
          if (!ph_q) sr_d = {sr_q[ADC_FRAME_BITS-2:0], bus.adc_so};
          else begin
            bc_d = bc_q + 4'd1;
            if (bc_q == 4'(ADC_FRAME_BITS - 1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d    = '0;
        valid_d  = frame_ok;
        err_d    = !frame_ok;
        sample_d = frame_ok ? sr_q[ADC_DATA_BITS-1:0] : sample_q;
        state_d  = GAP;
      end
      GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CONV_GAP - 1)) state_d = bus.en ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    lt_en_d = state_d != IDLE;
    cs_d    = !(state_d inside {SETUP, SHIFT});
    sclk_d  = !(state_d == SHIFT && !ph_d);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hc_q     <= '0;
      bc_q     <= '0;
      ph_q     <= 1'b0;
      sr_q     <= '0;
      sample_q <= '0;
      lt_en_q  <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hc_q     <= hc_d;
      bc_q     <= bc_d;
      ph_q     <= ph_d;
      sr_q     <= sr_d;
      sample_q <= sample_d;
      lt_en_q  <= lt_en_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  assign bus.lt5534_en    = lt_en_q;
  assign bus.adc_cs       = cs_q;
  assign bus.adc_clk      = sclk_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = err_q;
  adc_thresh_cmp #(
    .THRESH_HI(THRESH_HI),
    .THRESH_LO(THRESH_LO)
  ) u_cmp (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (state_d == IDLE),
    .sample_i      (sample_q),
    .sample_valid_i(valid_q),
    .rf_on_o       (bus.rf_on)
  );
endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: drives adc_sampler with a behavioural ADC and checks it against a frame-level model
module tb_adc_sampler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  adc_sampler_if bus();
  adc_sampler dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int now_cyc = 0;
  int last_v = 0;
  logic [11:0] sample_m = '0;
  logic rf_m = 1'b0;
  always @(posedge clk) now_cyc++;
  // Behavioural ADC: loads a word when CS falls, presents MSB first, advances after each SCLK rise.
  logic [15:0] words[$];
  logic [15:0] sent[$];
  logic [15:0] cur_word = '0;
  int unsigned rises = 0;
  int unsigned base = 0;
  always @(negedge bus.adc_cs) begin
    cur_word = words.size() > 0 ? words.pop_front() : 16'h0000;
    sent.push_back(cur_word);
    base = rises;
  end
  always @(posedge bus.adc_clk) rises++;
  assign bus.adc_so = (rises - base) < 16 ? cur_word[4'(15 - (rises - base))] : 1'b0;

  function automatic logic rf_next(input logic prev, input logic [11:0] s);
`ifdef ADC_SAMPLER_HYST_EN
    return s >= 12'd800 ? 1'b1 : s < 12'd700 ? 1'b0 : prev;
`else
    return s >= 12'd800;
`endif
  endfunction

  function automatic logic [15:0] pop_sent();
    return sent.size() > 0 ? sent.pop_front() : 16'hFFFF;
  endfunction

  task automatic wait_strobe(input int max, output int at, output logic v, output logic e,
                             output logic [11:0] s, output logic rf);
    at = -1; v = 1'b0; e = 1'b0; s = '0; rf = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (bus.sample_valid || bus.frame_err) begin
        at = now_cyc; v = bus.sample_valid; e = bus.frame_err; s = bus.sample;
        @(posedge clk); #1;
        rf = bus.rf_on;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.lt5534_en !== 1'b0) begin fails++; $display("FAIL reset_lt5534_en: got %b expected 0", bus.lt5534_en); end
    tests++; if (bus.adc_cs !== 1'b1) begin fails++; $display("FAIL reset_adc_cs: got %b expected 1", bus.adc_cs); end
    tests++; if (bus.adc_clk !== 1'b1) begin fails++; $display("FAIL reset_adc_clk: got %b expected 1", bus.adc_clk); end
    tests++; if (bus.sample !== 12'h000) begin fails++; $display("FAIL reset_sample: got %h expected 000", bus.sample); end
    tests++; if ({bus.sample_valid, bus.frame_err, bus.rf_on} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b expected 000", {bus.sample_valid, bus.frame_err, bus.rf_on}); end
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests++; if ({bus.lt5534_en, bus.adc_cs, bus.adc_clk} !== 3'b011) begin fails++; $display("FAIL idle_hold: got %b expected 011", {bus.lt5534_en, bus.adc_cs, bus.adc_clk}); end
  endtask

  task automatic test_first_frame();
    int cs_fall = -1, cs_rise = -1, cs_fall2 = -1, pulses = 0, lows = 0, vcyc = -1, nstrobe = 0;
    logic prev_clk = 1'b1, lt0 = 1'b0, rf_after = 1'b1;
    logic [11:0] s = '0;
    words.push_back(16'h0123);
    @(negedge clk); bus.en = 1'b1;
    for (int c = 0; c < 172; c++) begin
      @(posedge clk); #1;
      if (c == 0) lt0 = bus.lt5534_en;
      if (!bus.adc_cs) begin
        if (cs_fall < 0) cs_fall = c;
        else if (cs_rise >= 0 && cs_fall2 < 0) cs_fall2 = c;
      end else if (cs_fall >= 0 && cs_rise < 0) cs_rise = c;
      if (c < 166) begin
        if (!bus.adc_clk) lows++;
        if (!bus.adc_clk && prev_clk) pulses++;
      end
      prev_clk = bus.adc_clk;
      if (bus.sample_valid) begin nstrobe++; vcyc = c; s = bus.sample; last_v = now_cyc; end
      if (c == 167) rf_after = bus.rf_on;
    end
    tests++; if (lt0 !== 1'b1) begin fails++; $display("FAIL pwrup_lt5534_en: got %b expected 1", lt0); end
    tests++; if (cs_fall != 100) begin fails++; $display("FAIL cs_fall_cycle: got %0d expected 100", cs_fall); end
    tests++; if (pulses != 16) begin fails++; $display("FAIL sclk_pulses: got %0d expected 16", pulses); end
    tests++; if (lows != 32) begin fails++; $display("FAIL sclk_low_cycles: got %0d expected 32", lows); end
    tests++; if (vcyc != 166) begin fails++; $display("FAIL first_valid_cycle: got %0d expected 166", vcyc); end
    tests++; if (s !== 12'h123) begin fails++; $display("FAIL first_sample: got %h expected 123", s); end
    tests++; if (nstrobe != 1) begin fails++; $display("FAIL valid_one_cycle: got %0d strobes expected 1", nstrobe); end
    tests++; if (cs_rise != 165) begin fails++; $display("FAIL cs_rise_cycle: got %0d expected 165", cs_rise); end
    tests++; if (cs_fall2 - cs_rise != 5) begin fails++; $display("FAIL cs_high_gap: got %0d expected 5", cs_fall2 - cs_rise); end
    sample_m = 12'h123;
    rf_m = rf_next(rf_m, 12'h123);
    tests++; if (rf_after !== rf_m) begin fails++; $display("FAIL first_rf_on: got %b expected %b", rf_after, rf_m); end
    tests++; if (pop_sent() !== 16'h0123) begin fails++; $display("FAIL first_word_order: frame word mismatch"); end
  endtask

  task automatic test_back_to_back();
    int at;
    logic v, e, rf;
    logic [11:0] s;
    logic [15:0] w;
    for (int i = 0; i < 6; i++)
      words.push_back($urandom_range(0, 3) == 0 ? {4'($urandom_range(1, 15)), 12'($urandom)}
                                                 : {4'h0, 12'($urandom_range(600, 900))});
    for (int i = 0; i < 7; i++) begin
      wait_strobe(200, at, v, e, s, rf);
      tests++; if (at != last_v + 70) begin fails++; $display("FAIL b2b_period[%0d]: strobe at %0d expected %0d", i, at, last_v + 70); end
      w = pop_sent();
      if (w[15:12] == 4'h0) begin sample_m = w[11:0]; rf_m = rf_next(rf_m, w[11:0]); end
      tests++;
      if ({v, e, s} !== {w[15:12] == 4'h0, w[15:12] != 4'h0, sample_m}) begin
        fails++; $display("FAIL b2b_frame[%0d]: word %h got v=%b e=%b s=%h expected s=%h", i, w, v, e, s, sample_m);
      end
      tests++; if (rf !== rf_m) begin fails++; $display("FAIL b2b_rf_on[%0d]: got %b expected %b", i, rf, rf_m); end
      last_v = at;
    end
  endtask

  task automatic test_frame_err();
    int at;
    logic v, e, rf;
    logic [11:0] s;
    words.push_back(16'h8123);
    wait_strobe(200, at, v, e, s, rf);
    tests++; if (at != last_v + 70) begin fails++; $display("FAIL err_period: strobe at %0d expected %0d", at, last_v + 70); end
    tests++; if ({v, e} !== 2'b01) begin fails++; $display("FAIL err_strobe: got valid=%b err=%b expected 0/1", v, e); end
    tests++; if (s !== sample_m) begin fails++; $display("FAIL err_sample_hold: got %h expected %h", s, sample_m); end
    tests++; if (pop_sent() !== 16'h8123) begin fails++; $display("FAIL err_word_order: frame word mismatch"); end
    last_v = at;
  endtask

  task automatic test_thresh();
    int at;
    logic v, e, rf;
    logic [11:0] s;
    logic [11:0] vals[4] = '{12'd650, 12'd850, 12'd750, 12'd690};
`ifdef ADC_SAMPLER_HYST_EN
    logic [3:0] exp_rf = 4'b0110;
`else
    logic [3:0] exp_rf = 4'b0010;
`endif
    for (int i = 0; i < 4; i++) words.push_back({4'h0, vals[i]});
    for (int i = 0; i < 4; i++) begin
      wait_strobe(200, at, v, e, s, rf);
      void'(pop_sent());
      tests++; if ({v, s} !== {1'b1, vals[i]}) begin fails++; $display("FAIL thresh_sample[%0d]: got v=%b s=%0d expected %0d", i, v, s, vals[i]); end
      tests++; if (rf !== exp_rf[i]) begin fails++; $display("FAIL thresh_rf_on[%0d]: got %b expected %b", i, rf, exp_rf[i]); end
      last_v = at;
    end
    sample_m = vals[3];
    rf_m = exp_rf[3];
  endtask

  task automatic test_en_drop();
    int at, n = 0;
    logic v, e, rf, prev = 1'b1, cs_ok = 1'b1, lt3 = 1'b0, lt4 = 1'b1, rf4 = 1'b1;
    logic [11:0] s;
    words.push_back(16'd900);
    for (int i = 0; i < 300 && n < 5; i++) begin
      @(posedge clk); #1;
      if (!bus.adc_cs && !bus.adc_clk && prev) n++;
      prev = bus.adc_clk;
    end
    tests++; if (n != 5) begin fails++; $display("FAIL drop_reach_pulse5: got %0d pulses expected 5", n); end
    @(negedge clk); bus.en = 1'b0;
    wait_strobe(200, at, v, e, s, rf);
    tests++; if ({v, s} !== {1'b1, 12'd900}) begin fails++; $display("FAIL drop_frame_completes: got v=%b s=%0d expected 900", v, s); end
    tests++; if (rf !== 1'b1) begin fails++; $display("FAIL drop_rf_set: got %b expected 1", rf); end
    tests++; if (pop_sent() !== 16'd900) begin fails++; $display("FAIL drop_word_order: frame word mismatch"); end
    for (int k = 2; k < 22; k++) begin
      @(posedge clk); #1;
      if (!bus.adc_cs) cs_ok = 1'b0;
      if (k == 3) lt3 = bus.lt5534_en;
      if (k == 4) begin lt4 = bus.lt5534_en; rf4 = bus.rf_on; end
    end
    tests++; if (lt3 !== 1'b1) begin fails++; $display("FAIL drop_gap_powered: got %b expected 1", lt3); end
    tests++; if ({lt4, rf4} !== 2'b00) begin fails++; $display("FAIL drop_idle_entry: got lt=%b rf=%b expected 0/0", lt4, rf4); end
    tests++; if (cs_ok !== 1'b1) begin fails++; $display("FAIL drop_cs_stays_high: got low expected high"); end
    sample_m = 12'd900;
    rf_m = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0, cs_fall = -1, vcyc = -1;
    logic prev = 1'b1;
    logic [11:0] s = '0;
    words.push_back(16'h0ABC);
    @(negedge clk); bus.en = 1'b1;
    for (int i = 0; i < 400 && n < 8; i++) begin
      @(posedge clk); #1;
      if (!bus.adc_cs && !bus.adc_clk && prev) n++;
      prev = bus.adc_clk;
    end
    tests++; if (n != 8) begin fails++; $display("FAIL rst_reach_pulse8: got %0d pulses expected 8", n); end
    #3 reset = 1'b0;
    #1;
    tests++; if ({bus.adc_cs, bus.adc_clk, bus.lt5534_en} !== 3'b110) begin fails++; $display("FAIL rst_async_pins: got %b expected 110", {bus.adc_cs, bus.adc_clk, bus.lt5534_en}); end
    tests++; if ({bus.sample_valid, bus.frame_err, bus.rf_on, bus.sample} !== 15'h0) begin fails++; $display("FAIL rst_async_outputs: got v=%b e=%b rf=%b s=%h expected zero", bus.sample_valid, bus.frame_err, bus.rf_on, bus.sample); end
    void'(pop_sent());
    sample_m = '0;
    rf_m = 1'b0;
    words.push_back(16'h0456);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 170; c++) begin
      @(posedge clk); #1;
      if (!bus.adc_cs && cs_fall < 0) cs_fall = c;
      if ((bus.sample_valid || bus.frame_err) && vcyc < 0) begin vcyc = c; s = bus.sample; end
    end
    tests++; if (cs_fall != 100) begin fails++; $display("FAIL rst_pwrup_restart: cs fell at %0d expected 100", cs_fall); end
    tests++; if (vcyc != 166) begin fails++; $display("FAIL rst_first_strobe: got %0d expected 166", vcyc); end
    tests++; if (s !== 12'h456) begin fails++; $display("FAIL rst_sample: got %h expected 456", s); end
    @(negedge clk); bus.en = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    bus.en = 1'b0;
    #5;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_frame_err();
    test_thresh();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_sampler.md
# adc_sampler

Front-end detector stage for the loctag core. It powers the LT5534 RF detector and drives the 16-bit serial frame of the external 12-bit ADC (CS, SCLK, SO). Each completed frame yields one parallel sample with a valid strobe. A threshold comparator turns the sample stream into an RF-present level that the loctag core uses for trigger and MAC decisions.

## Interface
Parameters:
- `CLK_DIV`, 2 — SCLK half-period in `clk` cycles, range 1..15. At 50 MHz, 2 gives 12.5 MHz SCLK.
- `PWRUP_CYC`, 100 — `clk` cycles to wait after `lt5534_en` rises before the first frame, range 1..65535.
- `CONV_GAP`, 4 — `clk` cycles that CS stays high between frames, range 1..255.
- `THRESH_HI`, 12'd800 — rising threshold for `rf_on`.
- `THRESH_LO`, 12'd700 — falling threshold for `rf_on`. Ignored without `ADC_SAMPLER_HYST_EN`.

Ports:
- `clk` in 1 — 50 MHz system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `en` in 1 — run request (level).
- `lt5534_en` out 1 — detector power enable.
- `adc_cs` out 1 — ADC chip select, active-low.
- `adc_clk` out 1 — ADC serial clock. Idles high.
- `adc_so` in 1 — ADC serial data, MSB first.
- `sample` out 12 — last good sample. Holds its value between updates.
- `sample_valid` out 1 — one-cycle strobe when `sample` updates.
- `frame_err` out 1 — one-cycle strobe when a frame is rejected.
- `rf_on` out 1 — thresholded detector level.

## Operation
- The FSM has six states: IDLE, PWRUP, SETUP, SHIFT, DONE, GAP.
- IDLE:
  - `lt5534_en`=0, `adc_cs`=1, `adc_clk`=1.
  - `en`=1 moves to PWRUP.
- PWRUP:
  - `lt5534_en`=1. Counts `PWRUP_CYC` cycles, then moves to SETUP.
  - `en`=0 during PWRUP returns to IDLE at once.
- SETUP:
  - `adc_cs`=0 for exactly 1 cycle, with `adc_clk` still high.
  - Bit counter and half-period counter clear.
- SHIFT: 16 SCLK periods. Each period is `adc_clk`=0 for `CLK_DIV` cycles, then `adc_clk`=1 for `CLK_DIV` cycles.
  - `adc_so` is shifted into a 16-bit register on the last `clk` of each low phase, i.e. the cycle before `adc_clk` rises.
  - After the 16th high phase, move to DONE.
- DONE (1 cycle):
  - `adc_cs` returns to 1.
  - Bits [15:12] == 0: `sample` <= bits [11:0] and `sample_valid`=1.
  - Otherwise: `frame_err`=1 and `sample` is unchanged.
- GAP:
  - Holds `adc_cs`=1 for `CONV_GAP` cycles.
  - Then goes to SETUP if `en`=1, else to IDLE.
- `en` falling during SETUP, SHIFT or DONE does not abort. The frame completes, then the FSM goes through GAP to IDLE. CS is never released mid-frame.
- From IDLE, `lt5534_en` drops in the same cycle as the IDLE entry. `rf_on` is forced to 0 in IDLE.
- Comparator: evaluated only on the cycle `sample_valid`=1. `rf_on` updates on the next cycle. The comparison is unsigned 12-bit.

## Timing
- Reset values:
  - `lt5534_en`=0, `adc_cs`=1, `adc_clk`=1.
  - `sample`=0, `sample_valid`=0, `frame_err`=0, `rf_on`=0.
  - FSM is in IDLE.
- All outputs are registered.
- Frame period with `en` held high: 1 + 32·`CLK_DIV` + 1 + `CONV_GAP` cycles. With defaults this is 70 cycles, i.e. 714 kS/s.
- First `sample_valid` comes `PWRUP_CYC` + 1 + 32·`CLK_DIV` + 1 cycles after `en` is first sampled high.
- `rf_on` lags `sample_valid` by 1 cycle.
- `reset` asserted mid-frame: all outputs go to their reset values immediately (asynchronous). The partial frame is discarded and no strobe is issued.
- `adc_so` is not synchronised. The sample point lies `CLK_DIV` cycles after the `adc_clk` falling edge, which is sufficient margin for ADC data-valid.

## Configuration
- `ADC_SAMPLER_HYST_EN` defined: hysteresis comparator.
  - `rf_on` sets when `sample` ≥ `THRESH_HI`.
  - `rf_on` clears when `sample` < `THRESH_LO`.
  - Otherwise `rf_on` holds.
- Undefined: single threshold, `rf_on` = (`sample` ≥ `THRESH_HI`). `THRESH_LO` is unused.

## Structure
- Shared package `loctag_pkg` holds:
  - the FSM state enum;
  - `ADC_FRAME_BITS`=16, `ADC_DATA_BITS`=12, `ADC_LEAD_ZEROS`=4.
- One sub-module, `adc_thresh_cmp`: the comparator, including the macro-controlled hysteresis. It takes `sample`, `sample_valid` and a clear input driven by the IDLE state.
- The FSM, SCLK divider and shift register stay in `adc_sampler`.

## Test plan
- Reset, then `en`=1 with a model ADC returning 0x0123:
  - `lt5534_en` rises 1 cycle after `en`.
  - CS falls after 100 cycles.
  - 16 SCLK pulses of 4 cycles each.
  - `sample`=0x123 with `sample_valid` at cycle 166 after `en`.
- `en` held high:
  - consecutive `sample_valid` strobes are exactly 70 cycles apart;
  - CS is high for 5 cycles between frames (4 GAP + 1 DONE).
- ADC model returns 0x8123: `frame_err` pulses, `sample` holds its previous value, `sample_valid` stays 0.
- Samples 650, 850, 750, 690 with `ADC_SAMPLER_HYST_EN`: `rf_on` = 0, 1, 1, 0. Without the macro: `rf_on` = 0, 1, 0, 0.
- `en` dropped at SCLK pulse 5: the frame completes with a valid sample, then CS stays high, and after `CONV_GAP` the FSM is IDLE with `lt5534_en`=0 and `rf_on`=0.
- `reset` asserted at SCLK pulse 8: `adc_cs`=1, `adc_clk`=1 and `lt5534_en`=0 asynchronously, with no strobe. After release with `en`=1, the PWRUP wait restarts in full.
